// File: rtl/store_queue.sv
// store_queue: in-order store queue; allocates by ROB tag, captures AGU writeback, drains committed stores to the D-cache.
module store_queue #(
  parameter int SQ_ENTRIES = 8,
  parameter int PIPE_WIDTH = 2,
  parameter int TAG_WIDTH  = 4,
  parameter int XLEN       = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [PIPE_WIDTH-1:0]                alloc_req,
  input  logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] alloc_tag,
  output logic [PIPE_WIDTH-1:0]                alloc_gnt,
  input  logic                                 agu_val,
  input  logic [TAG_WIDTH-1:0]                 agu_tag,
  input  logic [XLEN-1:0]                      agu_addr,
  input  logic [XLEN-1:0]                      agu_data,
  input  logic [1:0]                           agu_size,
  input  logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0] commit_store_ids,
  input  logic [PIPE_WIDTH-1:0]                commit_store_vals,
  output logic                                 mem_req_val,
  input  logic                                 mem_req_rdy,
  output logic [XLEN-1:0]                      mem_req_addr,
  output logic [XLEN-1:0]                      mem_req_data,
  output logic [3:0]                           mem_req_wstrb,
  output logic [$clog2(SQ_ENTRIES):0]          sq_count,
  output logic                                 sq_empty
);
  localparam int PTR = $clog2(SQ_ENTRIES);
  localparam int CW  = PTR + 1;
  logic [SQ_ENTRIES-1:0] valid, addr_ok, committed, cmt_set, agu_hit;
  logic [TAG_WIDTH-1:0]  tag [SQ_ENTRIES];
  logic [XLEN-1:0]       addr [SQ_ENTRIES];
  logic [XLEN-1:0]       data [SQ_ENTRIES];
  logic [1:0]            size [SQ_ENTRIES];
  logic [PTR-1:0]        head, tail, idx;
  logic [PTR-1:0]        wr_idx [PIPE_WIDTH];
  logic [CW-1:0]         count, free, need, n_alloc, n_cmt;
  logic                  found, drain;
  logic [1:0]            lane;
  assign sq_count = count;
  assign sq_empty = count == '0;
  assign lane = addr[head][1:0];
  assign mem_req_val = valid[head] && committed[head] && addr_ok[head];
  assign mem_req_addr = mem_req_val ? {addr[head][XLEN-1:2], 2'b00} : '0;
  assign mem_req_data = mem_req_val ? data[head] << (8 * lane) : '0;
  assign mem_req_wstrb = !mem_req_val ? 4'b0000 :
                         size[head] == 2'd0 ? 4'b0001 << lane :
                         size[head] == 2'd1 ? 4'b0011 << lane : 4'b1111;
  assign drain = mem_req_val && mem_req_rdy;
  always_comb begin
    free = CW'(SQ_ENTRIES) - count;
    need = '0;
    n_alloc = '0;
    alloc_gnt = '0;
    for (int l = 0; l < PIPE_WIDTH; l++) begin
      need = need + CW'(alloc_req[l]);
      alloc_gnt[l] = alloc_req[l] && !flush && !rst && free >= need;
      wr_idx[l] = tail + PTR'(n_alloc);
      n_alloc = n_alloc + CW'(alloc_gnt[l]);
    end
    cmt_set = '0;
    for (int l = 0; l < PIPE_WIDTH; l++) begin
      found = 1'b0;
      for (int k = 0; k < SQ_ENTRIES; k++) begin
        idx = head + PTR'(k);
        if (!found && commit_store_vals[l] && valid[idx] && !committed[idx] && !cmt_set[idx] &&
            tag[idx] == commit_store_ids[l]) begin
          cmt_set[idx] = 1'b1;
          found = 1'b1;
        end
      end
    end
    agu_hit = '0;
    found = 1'b0;
    for (int k = 0; k < SQ_ENTRIES; k++) begin
      idx = head + PTR'(k);
      if (!found && agu_val && valid[idx] && !addr_ok[idx] && tag[idx] == agu_tag) begin
        agu_hit[idx] = 1'b1;
        found = 1'b1;
      end
    end
    n_cmt = '0;
    for (int k = 0; k < SQ_ENTRIES; k++)
      n_cmt = n_cmt + CW'(valid[k] && (committed[k] || cmt_set[k]));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      addr_ok <= '0;
      committed <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      for (int k = 0; k < SQ_ENTRIES; k++) begin
        if (agu_hit[k]) begin
          addr_ok[k] <= 1'b1;
          addr[k] <= agu_addr;
          data[k] <= agu_data;
          size[k] <= agu_size;
        end
        if (cmt_set[k]) committed[k] <= 1'b1;
        if (flush && !committed[k] && !cmt_set[k]) valid[k] <= 1'b0;
      end
      for (int l = 0; l < PIPE_WIDTH; l++)
        if (alloc_gnt[l]) begin
          valid[wr_idx[l]] <= 1'b1;
          addr_ok[wr_idx[l]] <= 1'b0;
          committed[wr_idx[l]] <= 1'b0;
          tag[wr_idx[l]] <= alloc_tag[l];
        end
      // Only committed entries survive a flush, and they are contiguous from head
      tail <= flush ? head + PTR'(n_cmt) : tail + PTR'(n_alloc);
      if (drain) begin
        valid[head] <= 1'b0;
        committed[head] <= 1'b0;
        addr_ok[head] <= 1'b0;
        head <= head + 1'b1;
      end
      count <= (flush ? n_cmt : count + n_alloc) - CW'(drain);
    end
  end
endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: directed checks of allocation, AGU capture, commit, drain, flush, wrap and reset.
module tb_store_queue;
  logic clk = 1'b0, rst, flush, agu_val, mem_req_rdy;
  logic [1:0] alloc_req, alloc_gnt, commit_store_vals, agu_size;
  logic [1:0][3:0] alloc_tag, commit_store_ids;
  logic [3:0] agu_tag, mem_req_wstrb;
  logic [31:0] agu_addr, agu_data, mem_req_addr, mem_req_data;
  logic mem_req_val, sq_empty;
  logic [3:0] sq_count;
  int nvec = 0, nerr = 0, ndrain;
  always #5 clk = ~clk;
  store_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .alloc_req(alloc_req), .alloc_tag(alloc_tag),
    .alloc_gnt(alloc_gnt), .agu_val(agu_val), .agu_tag(agu_tag), .agu_addr(agu_addr),
    .agu_data(agu_data), .agu_size(agu_size), .commit_store_ids(commit_store_ids),
    .commit_store_vals(commit_store_vals), .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_wstrb(mem_req_wstrb),
    .sq_count(sq_count), .sq_empty(sq_empty)
  );
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask
  task automatic idle();
    flush = 0; alloc_req = 0; alloc_tag = 0; agu_val = 0; agu_tag = 0; agu_addr = 0;
    agu_data = 0; agu_size = 0; commit_store_ids = 0; commit_store_vals = 0; mem_req_rdy = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask
  task automatic alloc(input logic [1:0] req, input logic [3:0] t0, input logic [3:0] t1);
    alloc_req = req; alloc_tag[0] = t0; alloc_tag[1] = t1;
  endtask
  task automatic agu(input logic [3:0] t, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    agu_val = 1; agu_tag = t; agu_addr = a; agu_data = d; agu_size = s;
  endtask
  task automatic commit(input logic [1:0] v, input logic [3:0] t0, input logic [3:0] t1);
    commit_store_vals = v; commit_store_ids[0] = t0; commit_store_ids[1] = t1;
  endtask
  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    chk("rst_count", 32'(sq_count), 0);
    chk("rst_empty", 32'(sq_empty), 1);
    chk("rst_val", 32'(mem_req_val), 0);
    chk("rst_addr", mem_req_addr, 0);
    chk("rst_wstrb", 32'(mem_req_wstrb), 0);
    alloc(2'b11, 4'd3, 4'd4); #1;
    chk("alloc_gnt", 32'(alloc_gnt), 32'b11);
    tick();
    chk("alloc_count", 32'(sq_count), 2);
    chk("alloc_empty", 32'(sq_empty), 0);
    commit(2'b01, 4'd3, 4'd0);
    tick();
    chk("no_addr_val", 32'(mem_req_val), 0);
    agu(4'd3, 32'h1002, 32'hAB, 2'd0);
    tick();
    chk("b_val", 32'(mem_req_val), 1);
    chk("b_addr", mem_req_addr, 32'h1000);
    chk("b_wstrb", 32'(mem_req_wstrb), 32'b0100);
    chk("b_data", mem_req_data, 32'h00AB0000);
    chk("b_count_pre", 32'(sq_count), 2);
    mem_req_rdy = 1;
    tick();
    chk("b_count_post", 32'(sq_count), 1);
    chk("b_val_post", 32'(mem_req_val), 0);
    agu(4'd4, 32'h2000, 32'h11223344, 2'd2);
    commit(2'b01, 4'd4, 4'd0);
    tick();
    chk("w_val", 32'(mem_req_val), 1);
    chk("w_addr", mem_req_addr, 32'h2000);
    chk("w_wstrb", 32'(mem_req_wstrb), 32'hF);
    chk("w_data", mem_req_data, 32'h11223344);
    mem_req_rdy = 1;
    tick();
    chk("w_empty", 32'(sq_empty), 1);
    for (int i = 0; i < 4; i++) begin
      alloc(2'b11, 4'(2 * i), 4'(2 * i + 1)); #1;
      chk("fill_gnt", 32'(alloc_gnt), 32'b11);
      tick();
    end
    chk("full_count", 32'(sq_count), 8);
    alloc(2'b11, 4'd8, 4'd9); #1;
    chk("full_gnt", 32'(alloc_gnt), 0);
    idle();
    agu(4'd0, 32'h100, 32'hA0, 2'd2);
    commit(2'b01, 4'd0, 4'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      alloc(2'b11, 4'd8, 4'd9); #1;
      chk("stall_gnt", 32'(alloc_gnt), 0);
      chk("stall_val", 32'(mem_req_val), 1);
      chk("stall_addr", mem_req_addr, 32'h100);
      chk("stall_data", mem_req_data, 32'hA0);
      tick();
    end
    mem_req_rdy = 1; alloc(2'b11, 4'd8, 4'd9); #1;
    chk("full_drain_gnt", 32'(alloc_gnt), 0);
    tick();
    alloc(2'b11, 4'd8, 4'd9); #1;
    chk("after_drain_gnt", 32'(alloc_gnt), 32'b01);
    idle();
    chk("after_drain_count", 32'(sq_count), 7);
    commit(2'b11, 4'd1, 4'd2);
    tick();
    flush = 1;
    alloc(2'b01, 4'd9, 4'd0); #1;
    chk("flush_gnt", 32'(alloc_gnt), 0);
    tick();
    chk("flush_count", 32'(sq_count), 2);
    alloc(2'b01, 4'd9, 4'd0);
    tick();
    chk("post_flush_count", 32'(sq_count), 3);
    agu(4'd2, 32'h200, 32'h22, 2'd2);
    tick();
    chk("order_hold", 32'(mem_req_val), 0);
    agu(4'd5, 32'h500, 32'h55, 2'd2);
    commit(2'b01, 4'd5, 4'd0);
    tick();
    chk("flushed_absent", 32'(mem_req_val), 0);
    agu(4'd1, 32'h106, 32'h5566, 2'd1);
    tick();
    chk("fl1_addr", mem_req_addr, 32'h104);
    chk("fl1_wstrb", 32'(mem_req_wstrb), 32'b1100);
    chk("fl1_data", mem_req_data, 32'h55660000);
    mem_req_rdy = 1;
    tick();
    chk("fl2_addr", mem_req_addr, 32'h200);
    chk("fl2_data", mem_req_data, 32'h22);
    mem_req_rdy = 1;
    tick();
    chk("fl_tag9_wait", 32'(mem_req_val), 0);
    chk("fl_tag9_count", 32'(sq_count), 1);
    agu(4'd9, 32'h300, 32'h99, 2'd2);
    commit(2'b01, 4'd9, 4'd0);
    tick();
    chk("tail_addr", mem_req_addr, 32'h300);
    mem_req_rdy = 1;
    tick();
    chk("tail_empty", 32'(sq_empty), 1);
    alloc(2'b11, 4'd10, 4'd11);
    tick();
    flush = 1;
    commit(2'b01, 4'd10, 4'd0);
    tick();
    chk("fc_count", 32'(sq_count), 1);
    agu(4'd10, 32'h401, 32'h7, 2'd0);
    tick();
    chk("fc_addr", mem_req_addr, 32'h400);
    chk("fc_wstrb", 32'(mem_req_wstrb), 32'b0010);
    chk("fc_data", mem_req_data, 32'h700);
    mem_req_rdy = 1;
    tick();
    chk("fc_empty", 32'(sq_empty), 1);
    ndrain = 0;
    for (int i = 0; i < 22; i++) begin
      if (i < 20) alloc(2'b01, 4'(i), 4'd0);
      if (i > 0 && i < 21) begin
        agu(4'(i - 1), 32'h1000 + 32'(4 * (i - 1)), 32'(i), 2'd2);
        commit(2'b01, 4'(i - 1), 4'd0);
      end
      mem_req_rdy = 1; #1;
      if (mem_req_val) begin
        chk("wrap_addr", mem_req_addr, 32'h1000 + 32'(4 * ndrain));
        ndrain++;
      end
      chk("wrap_bound", 32'(sq_count <= 4'd8), 1);
      tick();
    end
    chk("wrap_drains", 32'(ndrain), 20);
    chk("wrap_empty", 32'(sq_count), 0);
    alloc(2'b01, 4'd1, 4'd0);
    tick();
    agu(4'd1, 32'h600, 32'h1, 2'd2);
    commit(2'b01, 4'd1, 4'd0);
    tick();
    chk("rd_val", 32'(mem_req_val), 1);
    rst = 1; mem_req_rdy = 1;
    tick();
    rst = 0;
    chk("rd_val_after", 32'(mem_req_val), 0);
    chk("rd_count", 32'(sq_count), 0);
    chk("rd_empty", 32'(sq_empty), 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
